// File: rtl/shift_exec.sv
// rtl/shift_exec.sv - multi-cycle shift/parity execution unit with persistent shift-carry
module shift_exec #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sc_en,
    input  logic         sc_clr,
    input  logic         sc_pari,
    input  logic         sc_left,
    input  logic [2:0]   amt,
    input  logic [W-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] dout,
    output logic         sc_o,
    output logic         pari_o
);

    // Counter must hold both W (parity) and 7 (largest shift amount).
    localparam int CWB = $clog2(W + 1);
    localparam int CW  = (CWB > 3) ? CWB : 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NOP, OP_EN, OP_CLR, OP_PAR} op_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic           left_q, left_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   orig_q, orig_d;
    logic           acc_q, acc_d;
    logic           sc_q, sc_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           pari_q, pari_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic           fill;
    logic           out_bit;
    logic [W-1:0]   shifted;

    // One-bit step of the working register; parity and zero-fill shifts both use fill 0.
    always_comb begin
        fill    = (op_q == OP_EN) ? sc_q : 1'b0;
        out_bit = left_q ? data_q[W-1] : data_q[0];
        shifted = left_q ? {data_q[W-2:0], fill} : {fill, data_q[W-1:1]};
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        orig_d  = orig_q;
        acc_d   = acc_q;
        sc_d    = sc_q;
        dout_d  = dout_q;
        pari_d  = pari_q;
        done_d  = done_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    left_d  = sc_left;
                    data_d  = din;
                    orig_d  = din;
                    acc_d   = 1'b0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    if (sc_pari) begin
                        op_d  = OP_PAR;
                        cnt_d = CW'(W);
                    end else if (sc_clr) begin
                        op_d  = OP_CLR;
                        cnt_d = CW'(amt);
                    end else if (sc_en) begin
                        op_d  = OP_EN;
                        cnt_d = CW'(amt);
                    end else begin
                        op_d  = OP_NOP;
                        cnt_d = '0;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    data_d = shifted;
                    cnt_d  = cnt_q - CW'(1);
                    if (op_q == OP_PAR) begin
                        acc_d = acc_q ^ out_bit;
                    end else begin
                        sc_d = out_bit;
                    end
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_PAR: begin
                            pari_d = acc_q;
                            sc_d   = acc_q;
                            dout_d = orig_q;
                        end
                        OP_EN, OP_CLR: dout_d = data_q;
                        default:       dout_d = orig_q;
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            left_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            orig_q  <= '0;
            acc_q   <= 1'b0;
            sc_q    <= 1'b0;
            dout_q  <= '0;
            pari_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            orig_q  <= orig_d;
            acc_q   <= acc_d;
            sc_q    <= sc_d;
            dout_q  <= dout_d;
            pari_q  <= pari_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign dout   = dout_q;
    assign sc_o   = sc_q;
    assign pari_o = pari_q;

endmodule

// File: tb/tb_shift_exec.sv
// tb/tb_shift_exec.sv - directed self-checking bench for shift_exec
module tb_shift_exec;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sc_en;
    logic         sc_clr;
    logic         sc_pari;
    logic         sc_left;
    logic [2:0]   amt;
    logic [W-1:0] din;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         sc_o;
    logic         pari_o;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int cyc;
    int ndone;
    int done_cyc;

    shift_exec #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sc_en   (sc_en),
        .sc_clr  (sc_clr),
        .sc_pari (sc_pari),
        .sc_left (sc_left),
        .amt     (amt),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .dout    (dout),
        .sc_o    (sc_o),
        .pari_o  (pari_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; leaves time in the done cycle.
    task automatic run_op(input string tag, input logic p, input logic c, input logic e,
                          input logic l, input logic [2:0] a, input logic [W-1:0] d,
                          input int exp_lat);
        int n;
        bit seen;
        @(negedge clk);
        check({tag, " idle busy"}, busy, 1'b0);
        sc_pari = p; sc_clr = c; sc_en = e; sc_left = l; amt = a; din = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sc_pari = 1'b0; sc_clr = 1'b0; sc_en = 1'b0; din = '0; amt = '0;
        n = 1;
        seen = (done === 1'b1);
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = (done === 1'b1);
        end
        check({tag, " latency"}, n, exp_lat);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sc_en = 1'b0; sc_clr = 1'b0; sc_pari = 1'b0;
        sc_left = 1'b0; amt = '0; din = '0;
        #12;
        check("rst dout", dout, 8'h00);
        check("rst sc", sc_o, 1'b0);
        check("rst pari", pari_o, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_op("en_l3", 0, 0, 1, 1, 3'd3, 8'h96, 5);
        check("en_l3 dout", dout, 8'hB2);
        check("en_l3 sc", sc_o, 1'b0);
        check("en_l3 pari", pari_o, 1'b0);

        run_op("en_r1", 0, 0, 1, 0, 3'd1, 8'h01, 3);
        check("en_r1 dout", dout, 8'h00);
        check("en_r1 sc", sc_o, 1'b1);

        run_op("clr_r2", 0, 1, 0, 0, 3'd2, 8'h81, 4);
        check("clr_r2 dout", dout, 8'h20);
        check("clr_r2 sc", sc_o, 1'b0);

        run_op("en_l1", 0, 0, 1, 1, 3'd1, 8'h80, 3);
        check("en_l1 dout", dout, 8'h00);
        check("en_l1 sc", sc_o, 1'b1);

        run_op("par07", 1, 0, 0, 0, 3'd0, 8'h07, 10);
        check("par07 pari", pari_o, 1'b1);
        check("par07 sc", sc_o, 1'b1);
        check("par07 dout", dout, 8'h07);

        run_op("parB7", 1, 0, 0, 1, 3'd5, 8'hB7, 10);
        check("parB7 pari", pari_o, 1'b0);
        check("parB7 sc", sc_o, 1'b0);
        check("parB7 dout", dout, 8'hB7);

        run_op("par_en", 1, 0, 1, 1, 3'd3, 8'h01, 10);
        check("par_en pari", pari_o, 1'b1);
        check("par_en sc", sc_o, 1'b1);
        check("par_en dout", dout, 8'h01);

        run_op("nop", 0, 0, 0, 1, 3'd4, 8'h5A, 2);
        check("nop dout", dout, 8'h5A);
        check("nop sc", sc_o, 1'b1);
        check("nop pari", pari_o, 1'b1);

        run_op("amt0", 0, 0, 1, 1, 3'd0, 8'h3C, 2);
        check("amt0 dout", dout, 8'h3C);
        check("amt0 sc", sc_o, 1'b1);

        // start held high through a 7-step shift
        @(negedge clk);
        check("hold idle busy", busy, 1'b0);
        sc_clr = 1'b1; sc_left = 1'b1; amt = 3'd7; din = 8'hFF; start = 1'b1;
        ndone = 0;
        done_cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                done_cyc = i;
            end
        end
        check("hold done count", ndone, 1);
        check("hold done cycle", done_cyc, 9);
        check("hold busy drop", busy, 1'b0);
        check("hold dout", dout, 8'h80);
        check("hold sc", sc_o, 1'b1);
        @(negedge clk);
        check("hold reaccept", busy, 1'b1);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("hold second done", done, 1'b1);
        check("hold second dout", dout, 8'h80);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        sc_en = 1'b1; sc_clr = 1'b0; sc_left = 1'b1; amt = 3'd7; din = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst busy", busy, 1'b0);
        check("arst done", done, 1'b0);
        check("arst dout", dout, 8'h00);
        check("arst sc", sc_o, 1'b0);
        check("arst pari", pari_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_op("post_rst", 0, 0, 1, 0, 3'd4, 8'hF3, 6);
        check("post_rst dout", dout, 8'h6F);
        check("post_rst sc", sc_o, 1'b0);
        @(negedge clk);
        check("post_rst done low", done, 1'b0);
        check("post_rst busy low", busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/shift_exec.md
# shift_exec

Multi-cycle shift/parity execution unit for the datapath. It consumes the one-hot shift controls `sc_en`, `sc_clr`, `sc_pari` and `sc_left` produced by the shift-immediate decoder, plus a 3-bit shift amount. It operates on a W-bit operand one bit per cycle and maintains the architectural shift-carry bit `sc` across operations. It sits between the decode stage and register writeback, and stalls issue through `busy`.

## Interface
- `W`, default 8: operand width; `W` ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `sc_en`  in  1  shift through carry (vacated bit ← `sc`).
- `sc_clr`  in  1  shift with zero fill (vacated bit ← 0).
- `sc_pari`  in  1  compute parity of the operand.
- `sc_left`  in  1  1 = left (toward MSB), 0 = right.
- `amt`  in  3  shift count 0..7; ignored for parity.
- `din`  in  W  operand.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  single-cycle completion pulse.
- `dout`  out  W  result register.
- `sc_o`  out  1  current shift-carry register.
- `pari_o`  out  1  parity result register.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE with `start=1`: latch `din`, direction and op; load `cnt`; go to RUN.
  - Op priority: `sc_pari` > `sc_clr` > `sc_en` > no-op.
  - `cnt` = W for parity, `amt` for shifts, 0 for no-op.
- IDLE with `start=0`: hold all state.
- RUN with `cnt`≠0: perform one step and decrement `cnt`.
- RUN with `cnt`=0: go to DONE; no step is performed.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Shift step, left: `sc` ← data[W-1]; data ← {data[W-2:0], fill}.
- Shift step, right: `sc` ← data[0]; data ← {fill, data[W-1:1]}.
- Fill value: the current `sc` for `sc_en`, 0 for `sc_clr`.
- Parity step: shift a working copy in the latched direction, zero fill, and XOR the shifted-out bit into an accumulator that is cleared at start.
- On the parity transition to DONE:
  - `pari_o` and `sc` ← accumulator (1 = odd number of ones).
  - `dout` ← original latched `din`.
- Shift ops: on the transition to DONE, `dout` ← data; `pari_o` is unchanged.
- No-op: `dout` ← `din`; `sc` and `pari_o` are unchanged.
- `dout`, `sc_o` and `pari_o` hold until the next operation overwrites them. `sc` persists across operations.
- `start` in RUN or DONE is ignored; it is not queued.

## Timing
- Reset (asynchronous, immediate, including mid-operation): state=IDLE, `cnt`=0, `dout`=0, `sc_o`=0, `pari_o`=0, `busy`=0, `done`=0. Any partial result is discarded.
- Let edge E0 be the edge that accepts `start`.
  - `busy` goes high after E0.
  - `done` is high in the cycle after edge E0+N+1, where N = `cnt` loaded.
  - Latency: shift = `amt`+2 cycles; parity = W+2; no-op or `amt`=0 = 2.
- `dout`, `sc_o` and `pari_o` are valid in the same cycle as `done`.
- `busy` drops in the cycle after `done`. A new `start` is accepted on the first IDLE edge, giving back-to-back throughput of one operation per N+3 cycles.
- `amt`=0 with `sc_en`/`sc_clr`: `dout`=`din`, `sc` unchanged, `done` after 2 cycles.
- Inputs other than `start` are don't-care outside the accepting edge.

## Test plan
- Reset `sc`=0. `sc_en`, left, `amt`=3, `din`=0x96 -> `dout`=0xB2, `sc_o`=0, `done` 5 cycles after `start` (latency `amt`+2).
- After an op that leaves `sc`=1: `sc_clr`, right, `amt`=2, `din`=0x81 -> `dout`=0x20, `sc_o`=0. Then `sc_en`, left, `amt`=1, `din`=0x80 -> `dout`=0x00, `sc_o`=1.
- `sc_pari`, `din`=0x07 (W=8) -> `pari_o`=1, `sc_o`=1, `dout`=0x07, `done` 10 cycles after `start`. Repeat with `din`=0xB7 -> `pari_o`=0.
- Simultaneous `sc_pari`=`sc_en`=1 -> parity executes. All controls 0 -> `dout`=`din`, `sc_o` unchanged, 2-cycle `done`.
- Pulse `start` every cycle during a 7-step shift -> only the first operation runs. `done` pulses once; the next accept occurs only after `busy`=0.
- Assert `reset` asynchronously mid-RUN -> all outputs 0 immediately. A fresh `start` afterward completes normally.
